alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences two-operand ALU operations over an 8 x 16-bit
// register file using an external combinational ALU.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (op, ra, rb, rd, wb)
//   ld_valid/ld_ready       : register preload handshake (ld_reg, ld_data)
//   alu_a/alu_b/alu_op      : registered operands and op driven to the ALU
//   alu_q, alu_* flags      : ALU results, captured during EXEC
//   done                    : one-cycle pulse after write-back
//   flags                   : {overflow, less, equal, greater, zero}, registered
//   dbg_sel/dbg_data        : combinational register-file read port
module alu_sequencer #(
   parameter bit R0_ZERO = 1'b1,
   localparam int unsigned DW  = 16,
   localparam int unsigned AW  = 3,
   localparam int unsigned OPW = 4,
   localparam int unsigned FW  = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [OPW-1:0] cmd_op,
   input  logic [AW-1:0]  cmd_ra,
   input  logic [AW-1:0]  cmd_rb,
   input  logic [AW-1:0]  cmd_rd,
   input  logic           cmd_wb,
   input  logic           ld_valid,
   output logic           ld_ready,
   input  logic [AW-1:0]  ld_reg,
   input  logic [DW-1:0]  ld_data,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [DW-1:0]  alu_q,
   input  logic           alu_overflow,
   input  logic           alu_less,
   input  logic           alu_equal,
   input  logic           alu_greater,
   input  logic           alu_zero,
   output logic           done,
   output logic [FW-1:0]  flags,
   input  logic [AW-1:0]  dbg_sel,
   output logic [DW-1:0]  dbg_data
);

   localparam int unsigned NREG = 1 << AW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [AW-1:0]  ra;
      logic [AW-1:0]  rb;
      logic [AW-1:0]  rd;
      logic           wb;
   } cmd_t;

   state_t          state, state_nxt;
   cmd_t            cmd_q;
   logic [DW-1:0]   regs [NREG];
   logic [DW-1:0]   cap_q;
   logic [FW-1:0]   cap_flags;
   logic [DW-1:0]   rf_a, rf_b;
   logic            cmd_accept;
   logic            ld_write, wb_write;

   // Register-file read ports; r0 is forced to zero when R0_ZERO is set
   assign rf_a     = (R0_ZERO && cmd_q.ra == '0) ? '0 : regs[cmd_q.ra];
   assign rf_b     = (R0_ZERO && cmd_q.rb == '0) ? '0 : regs[cmd_q.rb];
   assign dbg_data = (R0_ZERO && dbg_sel == '0)  ? '0 : regs[dbg_sel];

   // Handshakes; a pending load blocks command acceptance
   assign ld_ready   = (state == S_IDLE) && !reset;
   assign cmd_ready  = (state == S_IDLE) && !ld_valid && !reset;
   assign cmd_accept = cmd_valid && cmd_ready;

   assign ld_write = (state == S_IDLE) && ld_valid && !(R0_ZERO && ld_reg == '0);
   assign wb_write = (state == S_WRITE) && cmd_q.wb && !(R0_ZERO && cmd_q.rd == '0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_accept) state_nxt = S_READ;
         S_READ:  state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: register file, command latch, ALU operand and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
         cmd_q     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         cap_q     <= '0;
         cap_flags <= '0;
         flags     <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (ld_write) regs[ld_reg] <= ld_data;
         if (cmd_accept) cmd_q <= '{op: cmd_op, ra: cmd_ra, rb: cmd_rb,
                                    rd: cmd_rd, wb: cmd_wb};
         if (state == S_READ) begin
            alu_a  <= rf_a;
            alu_b  <= rf_b;
            alu_op <= cmd_q.op;
         end
         if (state == S_EXEC) begin
            cap_q     <= alu_q;
            cap_flags <= {alu_overflow, alu_less, alu_equal, alu_greater, alu_zero};
         end
         if (wb_write) regs[cmd_q.rd] <= cap_q;
         if (state == S_WRITE) begin
            flags <= cap_flags;
            done  <= 1'b1;
         end
      end
   end

endmodule
